button_step_counter: RTL
========================

Name: button_step_counter

Overview:
Parametrised successor to the four-button up/down counter: a WIDTH-bit accumulator driven by four push-button channels (inc, dec, add step, sub step). Each channel has its own synchroniser, counter-based debouncer, single-shot and hold-to-auto-repeat FSM. Arithmetic is wrap-around or saturating, selected by parameter, with a one-cycle limit flag. Sits between board buttons/switches and LED/seven-segment display logic.

Parameters:
WIDTH, 16, accumulator and step width (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change debounced state (>=1)
REPEAT_DELAY, 16, cycles a debounced press is held before auto-repeat starts; 0 disables auto-repeat
REPEAT_PERIOD, 4, cycles between auto-repeat pulses (>=1)
SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp to 0 / 2^WIDTH-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_inc  in  1  raw button, count + 1
btn_dec  in  1  raw button, count - 1
btn_add  in  1  raw button, count + step
btn_sub  in  1  raw button, count - step
step  in  WIDTH  step operand, sampled in the cycle the add/sub op is applied
count  out  WIDTH  accumulator value
limit_hit  out  1  one-cycle pulse: applied op wrapped (SATURATE=0) or clamped (SATURATE=1)
press  out  4  per-channel conditioned pulses {sub,add,dec,inc}, debug/observability

Behaviour:
- One clock domain (clk); reset synchronous, active-high. On rst: count=0, limit_hit=0, press=0, all sync flops, debounce counters, debounced states = 0, all FSMs IDLE.
- Sync: two flops per channel (s1, s2).
- Debounce: counter cleared when s2 == db; incremented when s2 != db; when s2 != db and counter == DEBOUNCE_CYCLES-1, db <= s2, counter cleared. Any mismatch gap restarts the count.
- Repeat FSM per channel, states IDLE, HOLD, REPEAT:
  IDLE: db rise -> HOLD, emit press pulse, timer cleared.
  HOLD: timer counts; at REPEAT_DELAY-1 -> REPEAT, emit pulse, timer cleared. REPEAT_DELAY=0: stay in HOLD.
  REPEAT: pulse every REPEAT_PERIOD cycles.
  db fall in any state -> IDLE, no pulse.
- Press pulse is registered (press output) and applied to count at the following edge. Clean press latency: count changes at edge DEBOUNCE_CYCLES+3 after the first edge sampling the raw button high.
- Arbitration when several press pulses coincide: inc > dec > add > sub. Only the winner is applied; losers are dropped, not queued.
- Arithmetic computed at WIDTH+1 bits. Carry/borrow out -> limit_hit=1 in the update cycle. SATURATE=0: keep low WIDTH bits. SATURATE=1: clamp to 2^WIDTH-1 on overflow, 0 on underflow. Exact landing on a bound is not a limit.
- Reset mid-press or mid-repeat: all state cleared. A button still held after rst deasserts counts as a new press after normal latency.

Decomposition:
- Package button_count_pkg: channel index constants (CH_INC=0, CH_DEC=1, CH_ADD=2, CH_SUB=3), NUM_CH=4, repeat FSM state enum (IDLE, HOLD, REPEAT).
- Sub-module button_conditioner (parameters DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD; ports clk, rst, btn, press) holds sync, debounce and repeat FSM. Top instantiates it NUM_CH times in a generate loop, then adds arbitration and the accumulator.

Test Plan:
(WIDTH=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=4 unless stated)
- Reset: hold rst 3 cycles with buttons toggling -> count=0x00, limit_hit=0, press=0 throughout.
- Clean press: btn_inc high 10 cycles from edge k -> count 0x00->0x01 at edge k+7 only; no further change after release.
- Bounce: btn_inc three 2-cycle high glitches separated by 1-cycle lows -> count stays 0x00, press never asserted.
- Auto-repeat: btn_inc held so db stays high 30 cycles -> pulses at db-rise offsets 0, 16, 20, 24, 28 -> final count 0x05. With REPEAT_DELAY=0 -> count 0x01.
- Limits: count=0xFE, step=0x05, btn_add -> SATURATE=0: count 0x03, limit_hit one cycle; SATURATE=1: count 0xFF, limit_hit one cycle. At count 0x00, btn_dec -> 0xFF (wrap) / 0x00 (sat), limit_hit=1 both.
- Simultaneous and reset: btn_inc and btn_sub rise same cycle, step=0x10, count=0x20 -> count 0x21. Assert rst during inc auto-repeat with btn_inc still held -> count 0x00, then 0x01 exactly DEBOUNCE_CYCLES+3 edges after rst deasserts.

Source files
------------

// File: rtl/button_count_pkg.sv
// Shared definitions for the button step counter.
// Channel indices and the per-channel repeat FSM states.
package button_count_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_INC = 0;
    localparam int CH_DEC = 1;
    localparam int CH_ADD = 2;
    localparam int CH_SUB = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rpt_state_t;

endpackage

// File: rtl/button_step_counter_if.sv
// Button inputs, step operand and counter outputs.
// The board side is master, the counter is slave.
interface button_step_counter_if #(
    parameter int WIDTH = 16
);
    import button_count_pkg::*;

    logic              btn_inc;
    logic              btn_dec;
    logic              btn_add;
    logic              btn_sub;
    logic [WIDTH-1:0]  step;
    logic [WIDTH-1:0]  count;
    logic              limit_hit;
    logic [NUM_CH-1:0] press;

    modport master (
        output btn_inc, btn_dec, btn_add, btn_sub, step,
        input  count, limit_hit, press
    );

    modport slave (
        input  btn_inc, btn_dec, btn_add, btn_sub, step,
        output count, limit_hit, press
    );

endinterface

// File: rtl/button_conditioner.sv
// One button channel: synchroniser, debouncer and
// single-shot / hold-to-repeat pulse generator.
module button_conditioner
    import button_count_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int DW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic [DW-1:0] db_cnt;
    rpt_state_t    state;
    logic [TW-1:0] timer;

    // Synchronise, then accept a new level only after a run of stable samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db     <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Pulse on press, then after the hold delay pulse every repeat period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!db) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= HOLD;
                        timer <= '0;
                        press <= 1'b1;
                    end
                    HOLD: begin
                        if (REPEAT_DELAY == 0) begin
                            timer <= '0;
                        end else if (timer == DELAY_LAST) begin
                            state <= REPEAT;
                            timer <= '0;
                            press <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (timer == PERIOD_LAST) begin
                            timer <= '0;
                            press <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_step_counter.sv
// Four-button accumulator: conditioned inc/dec/add/sub
// pulses, fixed-priority arbitration, wrap or clamp.
module button_step_counter
    import button_count_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4,
    parameter bit SATURATE        = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    button_step_counter_if.slave bus
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] pulse;
    logic [WIDTH-1:0]  cnt_q;
    logic              lim_q;
    logic [WIDTH-1:0]  opnd;
    logic              do_op;
    logic              is_sub;
    logic [WIDTH:0]    nxt;

    assign raw = {bus.btn_sub, bus.btn_add, bus.btn_dec, bus.btn_inc};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_cond (
            .clk  (clk),
            .rst  (rst),
            .btn  (raw[i]),
            .press(pulse[i])
        );
    end

    // Pick the highest-priority pulse; the others are dropped.
    always_comb begin
        do_op  = 1'b1;
        is_sub = 1'b0;
        opnd   = '0;
        if (pulse[CH_INC]) begin
            opnd = WIDTH'(1);
        end else if (pulse[CH_DEC]) begin
            opnd   = WIDTH'(1);
            is_sub = 1'b1;
        end else if (pulse[CH_ADD]) begin
            opnd = bus.step;
        end else if (pulse[CH_SUB]) begin
            opnd   = bus.step;
            is_sub = 1'b1;
        end else begin
            do_op = 1'b0;
        end
        if (is_sub) begin
            nxt = {1'b0, cnt_q} - {1'b0, opnd};
        end else begin
            nxt = {1'b0, cnt_q} + {1'b0, opnd};
        end
    end

    // Apply the winning op; the extra bit flags carry or borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lim_q <= 1'b0;
        end else begin
            lim_q <= do_op & nxt[WIDTH];
            if (do_op) begin
                if (SATURATE && nxt[WIDTH]) begin
                    cnt_q <= is_sub ? '0 : '1;
                end else begin
                    cnt_q <= nxt[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.count     = cnt_q;
    assign bus.limit_hit = lim_q;
    assign bus.press     = pulse;

endmodule
